// File: rtl/fir_out_packer.sv
// fir_out_packer
//   Output stage behind the FIR core. It takes signed accumulator results on a
//   valid/ready handshake and scales each one by an arithmetic right shift.
//   The scaled value is saturated to OUT_W bits and buffered in a small word
//   FIFO. Each word is then sent MSB byte first on an 8-bit valid/ready stream.
//
//   Optional build macro: FIR_PACK_ROUND_EN
//     defined   -> round half up before the shift: (in_data + 2^(SHIFT-1)) >>> SHIFT
//     undefined -> plain truncation:                in_data >>> SHIFT
//
//   Parameter constraints:
//     OUT_W      multiple of 8, >= 8
//     FIFO_DEPTH power of 2, >= 2
//     SHIFT      in 1 .. ACC_W-OUT_W
module fir_out_packer #(
  parameter int ACC_W      = 24,
  parameter int SHIFT      = 4,
  parameter int OUT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ACC_W-1:0]                in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [7:0]                      out_data,
  output logic                            out_first,
  output logic [7:0]                      sat_cnt,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  // ---------------------------------------------------------------------------
  // Derived sizes and constants
  // ---------------------------------------------------------------------------
  localparam int AW = $clog2(FIFO_DEPTH);   // FIFO pointer width
  localparam int LW = AW + 1;               // FIFO level width
  localparam int B  = OUT_W / 8;            // bytes per word
  localparam int CW = (B > 1) ? $clog2(B) : 1;

  // Saturation limits, expressed in the ACC_W+1 bit scaled domain
  localparam logic signed [ACC_W:0] C_MAX =
    {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] C_MIN =
    {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

  // Serializer states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic signed [ACC_W:0]  w_ext;
  logic signed [ACC_W:0]  w_pre;
  logic signed [ACC_W:0]  w_s;
  logic                   w_sat_hi;
  logic                   w_sat_lo;
  logic                   w_sat;
  logic [OUT_W-1:0]       w_word;

  logic [OUT_W-1:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [LW-1:0]          r_level;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic [OUT_W-1:0]       w_head;

  logic [7:0]             r_sat_cnt;

  logic [0:0]             r_state;
  logic [OUT_W-1:0]       r_shift;
  logic [CW-1:0]          r_byte_cnt;
  logic                   r_out_valid;
  logic                   r_out_first;
  logic                   w_byte_hs;
  logic                   w_last;

  // ---------------------------------------------------------------------------
  // Scaling and saturation
  // ---------------------------------------------------------------------------
  // Sign-extend by one bit so that the rounding add cannot wrap.
  assign w_ext = {in_data[ACC_W-1], in_data};

`ifdef FIR_PACK_ROUND_EN
  localparam logic signed [ACC_W:0] C_HALF =
    {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
  assign w_pre = w_ext + C_HALF;
`else
  assign w_pre = w_ext;
`endif

  assign w_s      = w_pre >>> SHIFT;
  assign w_sat_hi = (w_s > C_MAX);
  assign w_sat_lo = (w_s < C_MIN);
  assign w_sat    = w_sat_hi | w_sat_lo;

  // Select the stored word: clamp to the limit on overflow, otherwise keep the low bits
  always_comb begin
    w_word = w_s[OUT_W-1:0];
    if (w_sat_hi) begin
      w_word = C_MAX[OUT_W-1:0];
    end else if (w_sat_lo) begin
      w_word = C_MIN[OUT_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Word FIFO
  // ---------------------------------------------------------------------------
  assign w_full   = (r_level == LW'(FIFO_DEPTH));
  assign w_empty  = (r_level == '0);
  assign in_ready = ~w_full;
  assign w_push   = in_valid & ~w_full;
  assign w_head   = r_mem[r_rd_ptr];

  // A byte handshake on the last byte of a word frees the shift register
  assign w_byte_hs = r_out_valid & out_ready;
  assign w_last    = (r_byte_cnt == CW'(B - 1));
  assign w_pop     = ~w_empty &
                     ((r_state == ST_IDLE) |
                      ((r_state == ST_SEND) & w_byte_hs & w_last));

  // Storage array: no reset is needed because the pointers gate every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  // Occupancy count; a simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Saturation event counter (sticks at 255)
  // ---------------------------------------------------------------------------
  // Count accepted words that saturated, without wrapping past 255
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat_cnt <= '0;
    end else if (w_push && w_sat && (r_sat_cnt != 8'hFF)) begin
      r_sat_cnt <= r_sat_cnt + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Byte serializer
  // ---------------------------------------------------------------------------
  // Load words from the FIFO head and shift them out MSB byte first.
  // When the last byte is accepted, the next word loads on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_byte_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_first <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_shift     <= w_head;
            r_byte_cnt  <= '0;
            r_out_valid <= 1'b1;
            r_out_first <= 1'b1;
            r_state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_byte_hs) begin
            if (w_last) begin
              if (!w_empty) begin
                r_shift     <= w_head;
                r_byte_cnt  <= '0;
                r_out_valid <= 1'b1;
                r_out_first <= 1'b1;
              end else begin
                r_shift     <= '0;
                r_byte_cnt  <= '0;
                r_out_valid <= 1'b0;
                r_out_first <= 1'b0;
                r_state     <= ST_IDLE;
              end
            end else begin
              r_shift     <= r_shift << 8;
              r_byte_cnt  <= r_byte_cnt + CW'(1);
              r_out_first <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_out_first <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid  = r_out_valid;
  assign out_first  = r_out_first;
  assign out_data   = r_shift[OUT_W-1 -: 8];
  assign sat_cnt    = r_sat_cnt;
  assign fifo_level = r_level;

endmodule

// File: doc/fir_out_packer.md
Name: fir_out_packer

Overview:
- Downstream neighbour of the FIR core in tt_um_hammal_fir_filter.
- Accepts signed accumulator results from the core on a valid/ready handshake.
- Scales each result by an arithmetic right shift, saturates it to OUT_W bits and buffers it in a small FIFO.
- Sends each buffered word MSB-byte-first on an 8-bit valid/ready byte stream that drives the pad outputs.

Parameters:
ACC_W, 24, width of signed accumulator input
SHIFT, 4, arithmetic right shift applied before saturation (1..ACC_W-OUT_W)
OUT_W, 16, signed output word width; must be a multiple of 8 and at least 8
FIFO_DEPTH, 4, word FIFO depth; power of 2, at least 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  accumulator result valid
in_ready  output  1  packer can accept a word
in_data  input  ACC_W  signed accumulator result
out_valid  output  1  out_data holds a valid byte
out_ready  input  1  consumer accepts the byte
out_data  output  8  current byte, MSB byte of the word first
out_first  output  1  high while out_data is the first (MS) byte of a word
sat_cnt  output  8  saturation event counter
fifo_level  output  $clog2(FIFO_DEPTH)+1  words stored in FIFO

Behaviour:
- Decided interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset state:
  - FIFO empty; fifo_level=0; in_ready=1.
  - out_valid=0, out_data=0x00, out_first=0.
  - sat_cnt=0; serializer in IDLE.
- Reset asserted mid-operation clears all state immediately. The word being sent and all buffered words are discarded.
- Input acceptance: a word is accepted on a clock edge where in_valid && in_ready. in_ready = !full.
  - A push while the FIFO is full is not possible, even if a pop happens on the same edge.
- Scaling (combinational, before the FIFO write):
  - s = in_data >>> SHIFT, computed in ACC_W+1 bits.
  - If s > 2^(OUT_W-1)-1, the stored word is 2^(OUT_W-1)-1.
  - If s < -2^(OUT_W-1), the stored word is -2^(OUT_W-1).
  - Otherwise the stored word is s[OUT_W-1:0].
- Saturation counter: sat_cnt increments by 1 for each accepted word that saturates. It holds at 255 and does not wrap.
- FIFO: circular buffer with wrap-around pointers. Pushing and popping on the same edge is allowed when the FIFO is neither full nor empty, and fifo_level is unchanged.
- Serializer FSM, with B = OUT_W/8 bytes per word:
  - IDLE:
    - If the FIFO is non-empty, pop the head word into the shift register and go to SEND.
    - On that edge set out_valid=1, out_first=1, out_data = word[OUT_W-1:OUT_W-8].
  - SEND: on each out_valid && out_ready edge, shift left by 8 and clear out_first.
  - Last byte handshake (byte B of the word):
    - If the FIFO is non-empty, load the next word on the same edge. There is no bubble, and out_first=1 again.
    - If the FIFO is empty, go to IDLE with out_valid=0.
  - While out_valid=1 and out_ready=0, out_data and out_first hold stable.
- Latency: a word accepted at edge N gives out_valid=1 after edge N+1, provided the serializer was IDLE.
- All outputs are registered except in_ready.

Optional Feature:
- Macro: FIR_PACK_ROUND_EN.
- Defined: round half up before the shift, s = (in_data + 2^(SHIFT-1)) >>> SHIFT. The addition is done in ACC_W+1 bits so it cannot wrap. Saturation then applies as normal.
- Undefined: plain truncation, s = in_data >>> SHIFT.

Test Plan:
- Basic word, defaults, out_ready=1: in_data=0x012345 -> bytes 0x12 (out_first=1) then 0x34 (out_first=0); first byte valid one edge after acceptance; sat_cnt=0.
- Saturation: inputs 0x7FFFFF then 0xF00000 -> words 0x7FFF and 0x8000 (bytes 0x7F,0xFF,0x80,0x00); sat_cnt=2.
- Rounding: in_data=0x000018 -> 0x0001 without FIR_PACK_ROUND_EN, 0x0002 with it. in_data=0xFFFFF8 -> 0xFFFF without, 0x0000 with.
- Backpressure and full:
  - Stimulus: hold out_ready=0 and push 6 words 0x000010..0x000060.
  - in_ready drops after 5 words are accepted: 1 in the shift register and 4 in the FIFO (fifo_level=4).
  - out_data is stable at 0x00 (MS byte of word 0x0001) throughout.
  - Release out_ready: bytes 00 01 00 02 00 03 00 04 00 05 follow with no gaps, then the 6th word 00 06.
- Reset mid-word: assert rst while the second byte is pending -> out_valid=0, fifo_level=0, sat_cnt=0, in_ready=1 immediately. After release, the next word is output cleanly starting with out_first=1.
